modulo_debounce_botoes: RTL and testbench

//  Multi-channel pushbutton conditioner: 2-FF sync, tick-based debounce, clean level plus 1-clk press/release pulses.

---
 rtl/modulo_debounce_botoes_pkg.sv | 19 +
 rtl/modulo_debounce_botoes_canal.sv | 123 ++++++++++++
 rtl/modulo_debounce_botoes.sv | 55 +++++
 tb/tb_modulo_debounce_botoes.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_debounce_botoes_pkg.sv
// Shared definitions for the pushbutton conditioner: per-channel state encoding,
// board default sample divider and a width helper.
package modulo_debounce_botoes_pkg;

   typedef enum logic [1:0] {
      SOLTO       = 2'b00,
      VERIF_PRESS = 2'b01,
      PRESSIONADO = 2'b11,
      VERIF_SOLTA = 2'b10
   } estado_t;

   // 1 ms sample period on the 50 MHz board clock
   localparam int DIV_AMOSTRA_50MHZ = 50000;

   function automatic int largura_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/modulo_debounce_botoes_canal.sv
// One button channel: 2-FF synchronizer, tick-driven debounce FSM with
// saturating stability counter, registered level and press/release pulses.
//
//  state        | meaning
//  SOLTO        | released, stable (nivel = 0)
//  VERIF_PRESS  | pressed samples being counted, level still 0
//  PRESSIONADO  | pressed, stable (nivel = 1)
//  VERIF_SOLTA  | released samples being counted, level still 1
module modulo_debounce_botoes_canal
   import modulo_debounce_botoes_pkg::*;
#(
   parameter int N_ESTAVEL = 10
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_n,
   input  logic tick,
   output logic nivel,
   output logic pulso_press,
   output logic pulso_solta
);

   localparam int                W_CNT   = $clog2(N_ESTAVEL + 1);
   localparam logic [W_CNT-1:0] CNT_FIM = W_CNT'(N_ESTAVEL);
   localparam logic [W_CNT-1:0] CNT_UM  = W_CNT'(1);

   logic             r_sync1;
   logic             r_sync2;
   estado_t          r_estado;
   logic [W_CNT-1:0] r_cnt;
   logic             r_nivel;
   logic             r_press;
   logic             r_solta;

   logic             w_amostra;
   logic [W_CNT-1:0] w_cnt_inc;

   assign w_amostra = ~r_sync2;
   assign w_cnt_inc = (r_cnt == CNT_FIM) ? r_cnt : r_cnt + CNT_UM;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_estado <= SOLTO;
         r_cnt    <= '0;
         r_nivel  <= 1'b0;
         r_press  <= 1'b0;
         r_solta  <= 1'b0;
      end else begin
         r_sync1 <= btn_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         r_solta <= 1'b0;
         if (tick) begin
            case (r_estado)
               SOLTO: begin
                  if (w_amostra) begin
                     if (N_ESTAVEL == 1) begin
                        r_estado <= PRESSIONADO;
                        r_nivel  <= 1'b1;
                        r_press  <= 1'b1;
                        r_cnt    <= '0;
                     end else begin
                        r_estado <= VERIF_PRESS;
                        r_cnt    <= CNT_UM;
                     end
                  end
               end
               VERIF_PRESS: begin
                  if (!w_amostra) begin
                     r_estado <= SOLTO;
                     r_cnt    <= '0;
                  end else if (w_cnt_inc == CNT_FIM) begin
                     r_estado <= PRESSIONADO;
                     r_nivel  <= 1'b1;
                     r_press  <= 1'b1;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               PRESSIONADO: begin
                  if (!w_amostra) begin
                     if (N_ESTAVEL == 1) begin
                        r_estado <= SOLTO;
                        r_nivel  <= 1'b0;
                        r_solta  <= 1'b1;
                        r_cnt    <= '0;
                     end else begin
                        r_estado <= VERIF_SOLTA;
                        r_cnt    <= CNT_UM;
                     end
                  end
               end
               VERIF_SOLTA: begin
                  if (w_amostra) begin
                     r_estado <= PRESSIONADO;
                     r_cnt    <= '0;
                  end else if (w_cnt_inc == CNT_FIM) begin
                     r_estado <= SOLTO;
                     r_nivel  <= 1'b0;
                     r_solta  <= 1'b1;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: begin
                  r_estado <= SOLTO;
                  r_nivel  <= 1'b0;
                  r_cnt    <= '0;
               end
            endcase
         end
      end
   end

   assign nivel       = r_nivel;
   assign pulso_press = r_press;
   assign pulso_solta = r_solta;

endmodule

// File: rtl/modulo_debounce_botoes.sv
// Multi-channel pushbutton conditioner: shared sample prescaler feeding
// N_CANAIS independent debounce channels.
module modulo_debounce_botoes
   import modulo_debounce_botoes_pkg::*;
#(
   parameter int N_CANAIS    = 4,
   parameter int DIV_AMOSTRA = DIV_AMOSTRA_50MHZ,
   parameter int N_ESTAVEL   = 10
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [N_CANAIS-1:0] btn_n,
   output logic [N_CANAIS-1:0] nivel,
   output logic [N_CANAIS-1:0] pulso_press,
   output logic [N_CANAIS-1:0] pulso_solta,
   output logic                tick_amostra
);

   localparam int                W_DIV   = largura_min1(DIV_AMOSTRA);
   localparam logic [W_DIV-1:0] DIV_FIM = W_DIV'(DIV_AMOSTRA - 1);

   logic [W_DIV-1:0] r_div;
   logic             r_tick;
   logic [W_DIV-1:0] w_div_prox;

   assign w_div_prox = (r_div == DIV_FIM) ? '0 : r_div + W_DIV'(1);

   // tick is registered from the next count so it is high exactly while r_div == DIV_FIM
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= w_div_prox;
         r_tick <= (w_div_prox == DIV_FIM);
      end
   end

   assign tick_amostra = r_tick;

   for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
      modulo_debounce_botoes_canal #(
         .N_ESTAVEL (N_ESTAVEL)
      ) u_canal (
         .clk         (clk),
         .clr         (clr),
         .btn_n       (btn_n[g]),
         .tick        (r_tick),
         .nivel       (nivel[g]),
         .pulso_press (pulso_press[g]),
         .pulso_solta (pulso_solta[g])
      );
   end

endmodule

// File: tb/tb_modulo_debounce_botoes.sv
// Bench for modulo_debounce_botoes: directed button sequences, expected pulses
// queued by the stimulus and checked by per-DUT monitors.
module tb_modulo_debounce_botoes;

   typedef struct {
      logic [1:0] press;
      logic [1:0] solta;
      logic [1:0] nivel;
      int         lo;
      int         hi;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr;
   logic [1:0] btn_a, btn_b;
   logic [1:0] nivel_a, press_a, solta_a;
   logic [1:0] nivel_b, press_b, solta_b;
   logic       tick_a, tick_b;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   modulo_debounce_botoes #(.N_CANAIS(2), .DIV_AMOSTRA(4), .N_ESTAVEL(3)) dut_a (
      .clk(clk), .clr(clr), .btn_n(btn_a), .nivel(nivel_a),
      .pulso_press(press_a), .pulso_solta(solta_a), .tick_amostra(tick_a));

   modulo_debounce_botoes #(.N_CANAIS(2), .DIV_AMOSTRA(1), .N_ESTAVEL(1)) dut_b (
      .clk(clk), .clr(clr), .btn_n(btn_b), .nivel(nivel_b),
      .pulso_press(press_b), .pulso_solta(solta_b), .tick_amostra(tick_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] p, input logic [1:0] s, input logic [1:0] nv,
                               input int lo, input int hi);
      exp_t e;
      e.press = p; e.solta = s; e.nivel = nv; e.lo = lo; e.hi = hi;
      return e;
   endfunction

   task automatic espera(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drena();
      int t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      n_cmp++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d/%0d pulses still pending, expected 0", q_a.size(), q_b.size());
         q_a.delete();
         q_b.delete();
      end
      espera(3);
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if ((press_a | solta_a) != 2'b00) begin
         if (q_a.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pulse_a: press=%b solta=%b at cyc %0d, expected none",
                     press_a, solta_a, cyc);
         end else begin
            e = q_a.pop_front();
            chk("press_a", 32'(press_a), 32'(e.press));
            chk("solta_a", 32'(solta_a), 32'(e.solta));
            chk("nivel_a", 32'(nivel_a), 32'(e.nivel));
            n_cmp++;
            if (cyc < e.lo || cyc > e.hi) begin
               n_err++;
               $display("FAIL latency_a: pulse at cyc %0d expected %0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if ((press_b | solta_b) != 2'b00) begin
         if (q_b.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pulse_b: press=%b solta=%b at cyc %0d, expected none",
                     press_b, solta_b, cyc);
         end else begin
            e = q_b.pop_front();
            chk("press_b", 32'(press_b), 32'(e.press));
            chk("solta_b", 32'(solta_b), 32'(e.solta));
            chk("nivel_b", 32'(nivel_b), 32'(e.nivel));
            n_cmp++;
            if (cyc < e.lo || cyc > e.hi) begin
               n_err++;
               $display("FAIL latency_b: pulse at cyc %0d expected %0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int r;
      clr   = 1'b0;
      btn_a = 2'b00;
      btn_b = 2'b11;
      espera(4);

      // reset state with keys held
      chk("rst_nivel_a", 32'(nivel_a), 32'(2'b00));
      chk("rst_press_a", 32'(press_a), 32'(2'b00));
      chk("rst_solta_a", 32'(solta_a), 32'(2'b00));
      chk("rst_tick_a",  32'(tick_a),  32'(1'b0));
      chk("rst_nivel_b", 32'(nivel_b), 32'(2'b00));
      chk("rst_tick_b",  32'(tick_b),  32'(1'b0));

      // 1: keys held through reset release -> simultaneous press after full debounce
      r = cyc;
      q_a.push_back(mk(2'b11, 2'b00, 2'b11, r + 11, r + 14));
      clr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         espera(1);
         chk("tick_a_phase", 32'(tick_a), 32'(((cyc - r) % 4) == 3));
      end
      drena();
      chk("t1_nivel", 32'(nivel_a), 32'(2'b11));

      c = cyc;
      q_a.push_back(mk(2'b00, 2'b01, 2'b10, c + 11, c + 14));
      btn_a[0] = 1'b1;
      drena();

      // 2: bouncy press -> one pulse, bounded latency from last falling edge
      c = cyc;
      q_a.push_back(mk(2'b01, 2'b00, 2'b11, c, c + 8 + 15));
      btn_a[0] = 1'b0; espera(5);
      btn_a[0] = 1'b1; espera(3);
      btn_a[0] = 1'b0;
      drena();
      chk("t2_nivel", 32'(nivel_a), 32'(2'b11));

      c = cyc;
      q_a.push_back(mk(2'b00, 2'b01, 2'b10, c + 11, c + 14));
      btn_a[0] = 1'b1;
      drena();

      // 3: short press (at most 2 ticks) is rejected
      btn_a[0] = 1'b0; espera(8);
      btn_a[0] = 1'b1; espera(30);
      chk("t3_nivel", 32'(nivel_a), 32'(2'b10));

      // 4: release with a one-tick glitch restarts the release count
      c = cyc;
      q_a.push_back(mk(2'b01, 2'b00, 2'b11, c + 11, c + 14));
      btn_a[0] = 1'b0;
      drena();
      c = cyc;
      q_a.push_back(mk(2'b00, 2'b01, 2'b10, c + 21, c + 24));
      btn_a[0] = 1'b1; espera(6);
      btn_a[0] = 1'b0; espera(4);
      chk("t4_nivel_mid", 32'(nivel_a[0]), 32'(1'b1));
      btn_a[0] = 1'b1;
      drena();
      chk("t4_nivel", 32'(nivel_a), 32'(2'b10));

      // 5: reset while channel 1 is mid-verification, channel 0 pressed
      c = cyc;
      q_a.push_back(mk(2'b00, 2'b10, 2'b00, c + 11, c + 14));
      btn_a[1] = 1'b1;
      drena();
      c = cyc;
      q_a.push_back(mk(2'b01, 2'b00, 2'b01, c + 11, c + 14));
      btn_a[0] = 1'b0;
      drena();
      btn_a[1] = 1'b0;
      espera(10);
      #2;
      clr = 1'b0;
      #1;
      chk("t5_async_nivel", 32'(nivel_a), 32'(2'b00));
      chk("t5_async_press", 32'(press_a), 32'(2'b00));
      chk("t5_async_tick",  32'(tick_a),  32'(1'b0));
      btn_a = 2'b11;
      espera(3);
      clr = 1'b1;
      espera(40);
      chk("t5_nivel_after", 32'(nivel_a), 32'(2'b00));

      // 6: DIV_AMOSTRA=1, N_ESTAVEL=1 -> level follows sync input one clock later
      c = cyc;
      q_b.push_back(mk(2'b01, 2'b00, 2'b01, c + 3, c + 3));
      btn_b[0] = 1'b0;
      espera(2);
      chk("t6_nivel_before", 32'(nivel_b[0]), 32'(1'b0));
      espera(1);
      chk("t6_nivel_after", 32'(nivel_b[0]), 32'(1'b1));
      for (int i = 0; i < 4; i++) begin
         chk("t6_tick", 32'(tick_b), 32'(1'b1));
         espera(1);
      end
      c = cyc;
      q_b.push_back(mk(2'b10, 2'b00, 2'b11, c + 3, c + 3));
      q_b.push_back(mk(2'b00, 2'b10, 2'b01, c + 4, c + 4));
      btn_b[1] = 1'b0;
      espera(1);
      btn_b[1] = 1'b1;
      drena();
      c = cyc;
      q_b.push_back(mk(2'b00, 2'b01, 2'b00, c + 3, c + 3));
      btn_b[0] = 1'b1;
      drena();
      chk("t6_nivel_end", 32'(nivel_b), 32'(2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
